alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage unit of the pipelined MIPS core. It is the consumer of the 3-bit alu_control code produced by the ALU-control decoder.
- Captures operands, alu_control and destination tag from ID/EX into an input register, computes the ALU result, and holds it in an EX/MEM output register with zero and overflow flags.
- Two-deep elastic pipeline with valid/ready handshake on both sides and a synchronous flush for branch/exception squash.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
TAGW, 5, destination-register tag width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all in-flight entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
alu_control  input  3  operation code (encoding below)
src_a  input  WIDTH  operand A (rs)
src_b  input  WIDTH  operand B (rt or sign-extended immediate)
in_tag  input  TAGW  destination register number
out_valid  output  1  result entry valid
out_ready  input  1  downstream accepts the result
result  output  WIDTH  ALU result
zero  output  1  result == 0
overflow  output  1  signed overflow on ADD/SUB
illegal_op  output  1  alu_control is an unsupported code
out_tag  output  TAGW  destination tag of the result

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0, s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=0, overflow=0, illegal_op=0, out_tag=0, and the input register is cleared.
- Encoding:
  - 000 AND; 001 OR; 010 ADD; 110 SUB (A-B).
  - 111 SLT, signed: result = {WIDTH-1 zeros, (A<B signed)}.
  - 011/100/101 illegal: result=0, illegal_op=1.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - overflow=1 only for ADD when both operands have the same sign and the result sign differs.
  - overflow=1 only for SUB when the operand signs differ and the result sign differs from A.
  - overflow=0 for all other ops, including SLT.
- zero = (result == 0). It is computed for every op, including illegal ops (zero=1).
- Stage 1 (input register), s1_valid:
  - Accepts when in_valid && in_ready.
  - s1_adv = !s2_valid || out_ready.
  - in_ready = !flush && (!s1_valid || s1_adv). This is combinational and does not depend on in_valid.
- Stage 2 (output register), s2_valid = out_valid:
  - Loads the ALU outputs computed from stage-1 contents when s1_valid && s1_adv.
  - Holds all outputs stable while out_valid && !out_ready.
- Latency: 2 cycles from input handshake to out_valid, with no backpressure. Throughput is 1 entry/cycle when out_ready stays high.
- Simultaneous events:
  - Stage-1 load and stage-1-to-stage-2 transfer may occur in the same cycle.
  - Stage-2 drain (out_ready=1) and refill occur in the same cycle.
- Backpressure: with out_ready=0 and both stages full, in_ready=0. No entry is lost or duplicated.
- Flush:
  - At the next edge, s1_valid=0 and s2_valid=0.
  - Any same-cycle input handshake is blocked, because in_ready is 0 during flush.
  - The data registers need not be cleared; out_valid=0 is sufficient.
  - Flush takes priority over all other events.
- Reset mid-operation: all entries are discarded immediately (asynchronously). After rst_n rises, the first accepted entry appears 2 cycles later.
- Outputs are registered; no combinational path from in_* to out_*.
- Unknown/X on inputs is ignored while in_valid=0.

Test Plan:
- ADD directed: src_a=0x7FFFFFFF, src_b=1, alu_control=010, tag=8, out_ready=1 -> after 2 cycles out_valid=1, result=0x80000000, overflow=1, zero=0, out_tag=8.
- SUB/SLT/logic stream: back-to-back SUB 5-5, SLT -1<1, AND 0xF0F0&0x0FF0, OR 0xF000|0x000F -> consecutive cycles give results 0 (zero=1), 1, 0x00F0, 0xF00F; overflow=0 on all four.
- Illegal code: alu_control=100, A=3, B=4 -> result=0, illegal_op=1, zero=1, overflow=0.
- Backpressure:
  - Setup: hold out_ready=0 and send 3 entries with tags 1, 2, 3.
  - Required: tags 1 and 2 are accepted, in_ready=0 while tag 3 is presented, and outputs stay stable.
  - Then release out_ready -> tags 1, 2, 3 emerge in order, with none dropped or duplicated.
- Flush: with both stages full, assert flush for 1 cycle together with in_valid=1 -> next cycle out_valid=0 and the input is not accepted. A new entry afterwards returns after 2 cycles.
- Async reset: drop rst_n mid-cycle with entries in flight -> out_valid=0 immediately without waiting for a clock edge. After release, the first new ADD 2+3 produces result 5 at +2 cycles.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU for the pipelined MIPS core: an ID/EX input register feeding an
// EX/MEM output register, with valid/ready handshakes on both sides and a synchronous flush.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op,
  output logic [TAGW-1:0]  out_tag
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam int unsigned MSB   = WIDTH - 1;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAGW-1:0]  s1_tag;

  logic             s1_adv_c;
  logic             s1_load_c;
  logic             s2_load_c;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             slt_c;
  logic [WIDTH-1:0] alu_result_c;
  logic             alu_overflow_c;
  logic             alu_illegal_c;

  // Handshake: stage 1 moves on when stage 2 is empty or draining; flush blocks intake.
  assign s1_adv_c  = !out_valid || out_ready;
  assign in_ready  = !flush && (!s1_valid || s1_adv_c);
  assign s1_load_c = in_valid && in_ready;
  assign s2_load_c = s1_valid && s1_adv_c && !flush;

  assign sum_c  = s1_a + s1_b;
  assign diff_c = s1_a - s1_b;
  assign slt_c  = $signed(s1_a) < $signed(s1_b);

  // ALU datapath on stage-1 contents.
  always_comb begin
    alu_result_c   = '0;
    alu_overflow_c = 1'b0;
    alu_illegal_c  = 1'b0;
    unique case (s1_op)
      OP_AND: alu_result_c = s1_a & s1_b;
      OP_OR:  alu_result_c = s1_a | s1_b;
      OP_ADD: begin
        alu_result_c   = sum_c;
        alu_overflow_c = (s1_a[MSB] == s1_b[MSB]) && (sum_c[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        alu_result_c   = diff_c;
        alu_overflow_c = (s1_a[MSB] != s1_b[MSB]) && (diff_c[MSB] != s1_a[MSB]);
      end
      OP_SLT: alu_result_c = {{(WIDTH-1){1'b0}}, slt_c};
      default: alu_illegal_c = 1'b1;
    endcase
  end

  // Stage 1: ID/EX input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load_c) begin
      s1_valid <= 1'b1;
      s1_op    <= alu_control;
      s1_a     <= src_a;
      s1_b     <= src_b;
      s1_tag   <= in_tag;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: EX/MEM output register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load_c) begin
      out_valid  <= 1'b1;
      result     <= alu_result_c;
      zero       <= (alu_result_c == '0);
      overflow   <= alu_overflow_c;
      illegal_op <= alu_illegal_c;
      out_tag    <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a reference model and a result scoreboard.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal_op;
  logic [4:0]  out_tag;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
    .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal_op(illegal_op), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Reference model in 64-bit signed arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] t);
    exp_t e;
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    e = '0;
    e.tag = t;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        r = sa + sb;
        e.res = r[31:0];
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        r = sa - sb;
        e.res = r[31:0];
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Scoreboard: compare every result handed downstream.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_result", 64'(result), 64'(e.res));
        chk("sb_zero", 64'(zero), 64'(e.z));
        chk("sb_overflow", 64'(overflow), 64'(e.o));
        chk("sb_illegal", 64'(illegal_op), 64'(e.il));
        chk("sb_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  task automatic present(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
    in_tag = t;
  endtask

  // Drive one entry until accepted (bounded), pushing its expected result on handshake.
  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t);
    bit got = 1'b0;
    present(op, a, b, t);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(op, a, b, t));
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    alu_control = 3'bxxx;
    src_a = 'x;
    src_b = 'x;
    chk("send_accepted", 64'(got), 64'd1);
  endtask

  // Offer an entry for exactly one cycle; withdraw if not accepted.
  task automatic try_send(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t);
    present(op, a, b, t);
    @(negedge clk);
    if (in_ready) q.push_back(model(op, a, b, t));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_latency(input string name);
    @(negedge clk);
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_res;
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_control = 3'bxxx;
    src_a = 'x;
    src_b = 'x;
    in_tag = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({zero, overflow, illegal_op}), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD overflow with latency check.
    send(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd8);
    check_latency("add");

    // Back-to-back SUB/SLT/AND/OR stream.
    send(3'b110, 32'd5, 32'd5, 5'd1);
    send(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd2);
    send(3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd3);
    send(3'b001, 32'h0000_F000, 32'h0000_000F, 5'd4);
    repeat (3) @(posedge clk);
    #1;

    // Illegal codes and SUB overflow edge.
    send(3'b100, 32'd3, 32'd4, 5'd9);
    send(3'b011, 32'd7, 32'd7, 5'd10);
    send(3'b101, 32'hFFFF_FFFF, 32'd0, 5'd11);
    send(3'b110, 32'h8000_0000, 32'd1, 5'd12);
    send(3'b111, 32'd1, 32'hFFFF_FFFF, 5'd13);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_stream", 64'(q.size()), 64'd0);

    // Backpressure: two accepted, third stalls with outputs held.
    out_ready = 1'b0;
    send(3'b010, 32'd10, 32'd1, 5'd1);
    send(3'b010, 32'd20, 32'd2, 5'd2);
    present(3'b010, 32'd30, 32'd3, 5'd3);
    @(negedge clk);
    held_res = result;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_tag", 64'(out_tag), 64'd1);
      chk("bp_result_hold", 64'(result), 64'(held_res));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'b010, 32'd30, 32'd3, 5'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_bp", 64'(q.size()), 64'd0);

    // Flush with both stages full and a same-cycle input.
    out_ready = 1'b0;
    send(3'b001, 32'd1, 32'd2, 5'd20);
    send(3'b001, 32'd3, 32'd4, 5'd21);
    present(3'b010, 32'd5, 32'd6, 5'd22);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_no_s1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    send(3'b010, 32'd100, 32'd23, 5'd23);
    check_latency("post_flush");

    // Asynchronous reset with entries in flight.
    out_ready = 1'b0;
    send(3'b000, 32'hFF, 32'h0F, 5'd5);
    send(3'b000, 32'hF0, 32'h3C, 5'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'b010, 32'd2, 32'd3, 5'd7);
    @(negedge clk);
    chk("arst_lat1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("arst_lat2", 64'(out_valid), 64'd1);
    chk("arst_add_result", 64'(result), 64'd5);
    @(posedge clk);
    #1;

    // Mixed traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      try_send(ops[$urandom_range(0, 7)], $urandom(), (i % 4 == 0) ? 32'h8000_0000 : $urandom(),
               5'(i));
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_random", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
